// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM for a tiny 8-bit accumulator-style CPU: fetch, decode, execute, writeback.
// Optional build macro ILLEGAL_TRAP_EN traps opcodes 0x5-0xE into HALT and raises illegal.
module cpu_control_fsm #(
    parameter logic [7:0] PC_LAST = 8'h06
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       instr_req,
    input  logic       instr_valid,
    input  logic [7:0] instr_data,
    input  logic [7:0] pc_in,
    output logic       pc_write_enable,
    output logic       rf_write_enable,
    output logic [1:0] rf_write_addr,
    output logic [1:0] rf_read_addr1,
    output logic [1:0] rf_read_addr2,
    output logic [1:0] alu_op,
    output logic       wb_sel,
    output logic [7:0] imm_out,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state;
    state_t     next_state;
    logic [7:0] instr;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       trap;
    logic       writes_rd;
    logic [1:0] alu_code;
    logic       fetch_accept;
    logic       imm_accept;

    assign opcode       = instr[7:4];
    assign rd           = instr[3:2];
    assign rs           = instr[1:0];
    assign fetch_accept = (state == S_FETCH) && instr_valid;
    assign imm_accept   = (state == S_FETCH_IMM) && instr_valid;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        trap       = 1'b0;
        writes_rd  = 1'b0;
        alu_code   = 2'b00;

`ifdef ILLEGAL_TRAP_EN
        trap = (opcode >= 4'h5) && (opcode <= 4'hE);
`endif

        case (opcode)
            OP_ADD: begin alu_code = 2'b01; writes_rd = 1'b1; end
            OP_SUB: begin alu_code = 2'b10; writes_rd = 1'b1; end
            OP_MOV: begin alu_code = 2'b00; writes_rd = 1'b1; end
            OP_LDI: begin alu_code = 2'b00; writes_rd = 1'b1; end
            default: begin alu_code = 2'b00; writes_rd = 1'b0; end
        endcase

        case (state)
            S_IDLE:      if (run) next_state = S_FETCH;
            S_FETCH:     if (instr_valid) next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LDI)               next_state = S_FETCH_IMM;
                else if ((opcode == OP_HLT) || trap) next_state = S_HALT;
                else                                 next_state = S_EXECUTE;
            end
            S_FETCH_IMM: if (instr_valid) next_state = S_EXECUTE;
            S_EXECUTE:   next_state = S_WRITEBACK;
            S_WRITEBACK: next_state = (pc_in == PC_LAST) ? S_HALT : S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_IDLE;
        endcase
    end

    // Outputs are registered one stage behind the state that owns them, so the
    // write pulse lands in the cycle after WRITEBACK and never meets a PC pulse.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            instr           <= 8'h00;
            instr_req       <= 1'b0;
            pc_write_enable <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= 2'b00;
            rf_read_addr1   <= 2'b00;
            rf_read_addr2   <= 2'b00;
            alu_op          <= 2'b00;
            wb_sel          <= 1'b0;
            imm_out         <= 8'h00;
            halted          <= 1'b0;
        end else begin
            state           <= next_state;
            instr_req       <= (next_state == S_FETCH) || (next_state == S_FETCH_IMM);
            pc_write_enable <= fetch_accept || imm_accept;
            if (fetch_accept) instr   <= instr_data;
            if (imm_accept)   imm_out <= instr_data;
            if (state == S_DECODE) begin
                rf_read_addr1 <= rd;
                rf_read_addr2 <= rs;
            end
            alu_op          <= (state == S_EXECUTE) ? alu_code : 2'b00;
            wb_sel          <= (state == S_EXECUTE) && (opcode == OP_LDI);
            rf_write_enable <= (state == S_WRITEBACK) && writes_rd;
            rf_write_addr   <= ((state == S_WRITEBACK) && writes_rd) ? rd : 2'b00;
            halted          <= halted || (next_state == S_HALT);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal <= 1'b0;
        else       illegal <= illegal || ((state == S_DECODE) && trap);
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: hand-computed cycle-by-cycle expectations per scenario.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       instr_req;
    logic       instr_valid = 1'b0;
    logic [7:0] instr_data = 8'h00;
    logic [7:0] pc_in = 8'h00;
    logic       pc_write_enable;
    logic       rf_write_enable;
    logic [1:0] rf_write_addr;
    logic [1:0] rf_read_addr1;
    logic [1:0] rf_read_addr2;
    logic [1:0] alu_op;
    logic       wb_sel;
    logic [7:0] imm_out;
    logic       halted;
    logic       illegal;

    integer errors = 0;
    integer checks = 0;
    integer pc_pulses = 0;
    integer rf_pulses = 0;
    integer both_pulses = 0;
    integer pc_snap;
    integer rf_snap;

    cpu_control_fsm #(.PC_LAST(8'h06)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_req(instr_req),
        .instr_valid(instr_valid), .instr_data(instr_data), .pc_in(pc_in),
        .pc_write_enable(pc_write_enable), .rf_write_enable(rf_write_enable),
        .rf_write_addr(rf_write_addr), .rf_read_addr1(rf_read_addr1),
        .rf_read_addr2(rf_read_addr2), .alu_op(alu_op), .wb_sel(wb_sel),
        .imm_out(imm_out), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Count cycles in which each pulse is high, and cycles where both are high.
    always @(negedge clk) begin
        if (!reset) begin
            if (pc_write_enable) pc_pulses = pc_pulses + 1;
            if (rf_write_enable) rf_pulses = rf_pulses + 1;
            if (pc_write_enable && rf_write_enable) both_pulses = both_pulses + 1;
        end
    end

    function automatic logic [21:0] all_outputs();
        return {instr_req, pc_write_enable, rf_write_enable, rf_write_addr, rf_read_addr1,
                rf_read_addr2, alu_op, wb_sel, imm_out, halted, illegal};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr_data = 8'h00; pc_in = 8'h00;
        step(2);
        reset = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== 22'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        step(2);
        reset = 1'b0;
        pc_snap = pc_pulses; rf_snap = rf_pulses;
        step(2);
        checks++;
        if (all_outputs() !== 22'd0 || pc_pulses !== pc_snap || rf_pulses !== rf_snap) begin
            errors++; $display("FAIL reset_release: outputs %h pc %0d rf %0d expected 0 and no pulses",
                               all_outputs(), pc_pulses - pc_snap, rf_pulses - rf_snap);
        end
    endtask

    // ADD R1,R2 from IDLE: accept on edge 2, write pulse in the 4th cycle after it.
    task automatic test_add();
        pc_in = 8'h00; run = 1'b1; instr_valid = 1'b1; instr_data = 8'h16;
        step(1);
        run = 1'b0;
        checks++;
        if (instr_req !== 1'b1) begin errors++; $display("FAIL add_req: got %b expected 1", instr_req); end
        step(1);
        instr_valid = 1'b0;
        checks++;
        if ({pc_write_enable, rf_write_enable} !== 2'b10) begin
            errors++; $display("FAIL add_pc_pulse: pc/rf %b%b expected 10", pc_write_enable, rf_write_enable);
        end
        step(1);
        checks++;
        if ({pc_write_enable, rf_read_addr1, rf_read_addr2} !== 5'b0_01_10) begin
            errors++; $display("FAIL add_read_addr: pc %b a1 %0d a2 %0d expected 0 1 2",
                               pc_write_enable, rf_read_addr1, rf_read_addr2);
        end
        step(1);
        checks++;
        if ({alu_op, wb_sel, rf_write_enable} !== 4'b01_0_0) begin
            errors++; $display("FAIL add_alu: alu %b wb %b rf %b expected 01 0 0", alu_op, wb_sel, rf_write_enable);
        end
        step(1);
        checks++;
        if ({rf_write_enable, rf_write_addr, alu_op, instr_req} !== 6'b1_01_00_1) begin
            errors++; $display("FAIL add_write: rf %b addr %0d alu %b req %b expected 1 1 00 1",
                               rf_write_enable, rf_write_addr, alu_op, instr_req);
        end
        step(1);
        checks++;
        if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL add_pulse_width: rf %b expected 0", rf_write_enable); end
    endtask

    // LDI R2 (0x48) then immediate 0xA5.
    task automatic test_ldi();
        pc_snap = pc_pulses; rf_snap = rf_pulses;
        instr_valid = 1'b1; instr_data = 8'h48;
        step(1);
        instr_data = 8'hA5;
        step(1);
        checks++;
        if ({instr_req, pc_write_enable, rf_read_addr1, rf_read_addr2} !== 6'b1_0_10_00) begin
            errors++; $display("FAIL ldi_fetch_imm: req %b pc %b a1 %0d a2 %0d expected 1 0 2 0",
                               instr_req, pc_write_enable, rf_read_addr1, rf_read_addr2);
        end
        step(1);
        instr_valid = 1'b0;
        checks++;
        if ({pc_write_enable, imm_out} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL ldi_imm: pc %b imm %h expected 1 a5", pc_write_enable, imm_out);
        end
        step(1);
        checks++;
        if ({wb_sel, alu_op} !== 3'b1_00) begin
            errors++; $display("FAIL ldi_wb_sel: wb %b alu %b expected 1 00", wb_sel, alu_op);
        end
        step(1);
        checks++;
        if ({rf_write_enable, rf_write_addr, wb_sel} !== 4'b1_10_0) begin
            errors++; $display("FAIL ldi_write: rf %b addr %0d wb %b expected 1 2 0", rf_write_enable, rf_write_addr, wb_sel);
        end
        step(1);
        checks++;
        if (pc_pulses - pc_snap !== 2 || rf_pulses - rf_snap !== 1) begin
            errors++; $display("FAIL ldi_pulse_count: pc %0d rf %0d expected 2 1", pc_pulses - pc_snap, rf_pulses - rf_snap);
        end
    endtask

    // Stall in FETCH for 10 cycles, then a NOP: one PC pulse, no write.
    task automatic test_stall_nop();
        int req_drops = 0;
        pc_snap = pc_pulses; rf_snap = rf_pulses;
        instr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (instr_req !== 1'b1) req_drops++;
        end
        checks++;
        if (req_drops !== 0 || pc_pulses !== pc_snap || rf_pulses !== rf_snap) begin
            errors++; $display("FAIL stall_hold: req drops %0d pc %0d rf %0d expected 0 0 0",
                               req_drops, pc_pulses - pc_snap, rf_pulses - rf_snap);
        end
        instr_valid = 1'b1; instr_data = 8'h00;
        step(1);
        instr_valid = 1'b0;
        checks++;
        if (pc_write_enable !== 1'b1) begin errors++; $display("FAIL nop_pc_pulse: got %b expected 1", pc_write_enable); end
        step(4);
        checks++;
        if (pc_pulses - pc_snap !== 1 || rf_pulses !== rf_snap || instr_req !== 1'b1) begin
            errors++; $display("FAIL nop_no_write: pc %0d rf %0d req %b expected 1 0 1",
                               pc_pulses - pc_snap, rf_pulses - rf_snap, instr_req);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        start_run();
        rf_snap = rf_pulses;
        instr_valid = 1'b1; instr_data = 8'h70;
        step(1);
        instr_valid = 1'b0;
        step(1);
`ifdef ILLEGAL_TRAP_EN
        checks++;
        if ({illegal, halted, instr_req} !== 3'b110) begin
            errors++; $display("FAIL illegal_trap: illegal %b halted %b req %b expected 1 1 0", illegal, halted, instr_req);
        end
`else
        step(3);
        checks++;
        if ({illegal, halted, instr_req} !== 3'b001 || rf_pulses !== rf_snap) begin
            errors++; $display("FAIL illegal_as_nop: illegal %b halted %b req %b rf %0d expected 0 0 1 0",
                               illegal, halted, instr_req, rf_pulses - rf_snap);
        end
`endif
    endtask

    task automatic test_halt();
        do_reset();
        start_run();
        instr_valid = 1'b1; instr_data = 8'hF0;
        step(1);
        instr_valid = 1'b0;
        step(1);
        checks++;
        if ({halted, instr_req} !== 2'b10) begin
            errors++; $display("FAIL halt_enter: halted %b req %b expected 1 0", halted, instr_req);
        end
        pc_snap = pc_pulses; rf_snap = rf_pulses;
        instr_data = 8'h16;
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            instr_valid = ~i[0];
            step(1);
        end
        run = 1'b0; instr_valid = 1'b0;
        checks++;
        if ({halted, instr_req} !== 2'b10 || pc_pulses !== pc_snap || rf_pulses !== rf_snap) begin
            errors++; $display("FAIL halt_sticky: halted %b req %b pc %0d rf %0d expected 1 0 0 0",
                               halted, instr_req, pc_pulses - pc_snap, rf_pulses - rf_snap);
        end
        do_reset();
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b expected 0", halted); end
    endtask

    // ADD at pc_in == PC_LAST: the write still happens, then HALT.
    task automatic test_pc_last();
        do_reset();
        start_run();
        pc_in = 8'h06; instr_valid = 1'b1; instr_data = 8'h16;
        step(1);
        instr_valid = 1'b0;
        step(3);
        checks++;
        if ({halted, rf_write_enable, rf_write_addr, instr_req} !== 5'b1_1_01_0) begin
            errors++; $display("FAIL pc_last_halt: halted %b rf %b addr %0d req %b expected 1 1 1 0",
                               halted, rf_write_enable, rf_write_addr, instr_req);
        end
        step(1);
        checks++;
        if ({halted, rf_write_enable} !== 2'b10) begin
            errors++; $display("FAIL pc_last_after: halted %b rf %b expected 1 0", halted, rf_write_enable);
        end
    endtask

    // Reset lands while SUB R1,R3 sits in WRITEBACK, before its write pulse.
    task automatic test_reset_mid_writeback();
        do_reset();
        start_run();
        pc_in = 8'h00; instr_valid = 1'b1; instr_data = 8'h27;
        step(1);
        instr_valid = 1'b0;
        step(2);
        checks++;
        if (alu_op !== 2'b10) begin errors++; $display("FAIL sub_alu: got %b expected 10", alu_op); end
        rf_snap = rf_pulses;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== 22'd0) begin
            errors++; $display("FAIL wb_reset_outputs: got %h expected 0", all_outputs());
        end
        step(1);
        reset = 1'b0;
        step(2);
        checks++;
        if (all_outputs() !== 22'd0 || rf_pulses !== rf_snap) begin
            errors++; $display("FAIL wb_reset_release: outputs %h rf %0d expected 0 0", all_outputs(), rf_pulses - rf_snap);
        end
    endtask

    task automatic test_exclusive_pulses();
        checks++;
        if (both_pulses !== 0) begin
            errors++; $display("FAIL pulse_overlap: got %0d cycles expected 0", both_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldi();
        test_stall_nop();
        test_illegal();
        test_halt();
        test_pc_last();
        test_reset_mid_writeback();
        test_exclusive_pulses();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
